// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, one-word TX holding register,
// multi-word frames while cs_n stays low.
module spi_target #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  cs_n,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  tx_underrun,
   output logic                  frame_err
);

   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   logic [DATA_WIDTH-1:0] tx_hold, tx_shift, rx_shift;
   logic                  hold_full, empty_load, word_done;
   logic [CW-1:0]         bit_cnt;
   logic                  accept, load, take;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q <= '0;
         mosi_q <= '0;
         cs_q   <= '0;
         sclk_d <= 1'b0;
         cs_d   <= 1'b0;
      end else begin
         sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
         cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
         sclk_d <= sclk_s;
         cs_d   <= cs_s;
      end
   end

   assign sclk_s    = sclk_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_q[SYNC_STAGES-1];
   assign cs_s      = cs_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   assign accept = tx_valid & ~hold_full;
   assign load   = (state == IDLE && cs_fall) ||
                   (state == ACTIVE && !cs_rise && sclk_fall &&
                    bit_cnt == '0 && word_done);
   assign take   = load & hold_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cs_fall) state_nxt = ACTIVE;
         ACTIVE:  if (cs_rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      miso = 1'b0;
      busy = 1'b0;
      if (state == ACTIVE) begin
         miso = tx_shift[DATA_WIDTH-1];
         busy = 1'b1;
      end
   end

   assign tx_ready = ~hold_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_hold   <= '0;
         hold_full <= 1'b0;
      end else if (take) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         tx_hold   <= tx_data;
         hold_full <= 1'b1;
      end
   end

   // Underrun is reported when the empty word actually starts clocking,
   // so the idle reload after a frame's last bit stays silent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_shift    <= '0;
         rx_shift    <= '0;
         rx_data     <= '0;
         bit_cnt     <= '0;
         empty_load  <= 1'b0;
         word_done   <= 1'b0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
         if (load) begin
            tx_shift   <= hold_full ? tx_hold : '0;
            empty_load <= ~hold_full;
            word_done  <= 1'b0;
            bit_cnt    <= '0;
         end else if (state == ACTIVE) begin
            if (cs_rise) begin
               frame_err  <= (bit_cnt != '0);
               bit_cnt    <= '0;
               word_done  <= 1'b0;
               empty_load <= 1'b0;
            end else if (sclk_rise) begin
               rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
               if (bit_cnt == '0 && empty_load) begin
                  tx_underrun <= 1'b1;
                  empty_load  <= 1'b0;
               end
               if (bit_cnt == LAST) begin
                  rx_data   <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                  rx_valid  <= 1'b1;
                  bit_cnt   <= '0;
                  word_done <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end else if (sclk_fall && bit_cnt != '0) begin
               tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: received words are checked against a queue
// of expected bytes filled as each word is driven.
module tb_spi_target;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       cs_n = 1'b1;
   logic       miso;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       tx_underrun;
   logic       frame_err;

   int checks = 0;
   int errors = 0;
   int rxv_cnt = 0;
   int und_cnt = 0;
   int fe_cnt = 0;
   logic rxv_prev = 1'b0;
   logic [7:0] exp_rx[$];

   spi_target #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .tx_underrun(tx_underrun), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            rxv_cnt++;
            checks++;
            if (exp_rx.size() == 0) begin
               errors++;
               $display("FAIL rx_unexpected got %h", rx_data);
            end else begin
               logic [7:0] e;
               e = exp_rx.pop_front();
               if (rx_data !== e) begin
                  errors++;
                  $display("FAIL rx_data got %h want %h", rx_data, e);
               end
            end
            if (rxv_prev) begin
               errors++;
               $display("FAIL rx_valid_width got 2+ cycles want 1");
            end
         end
         if (tx_underrun) und_cnt++;
         if (frame_err) fe_cnt++;
      end
      rxv_prev = rx_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] d);
      int n;
      n = 0;
      tx_data = d;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 50) begin
         tick(1);
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL load_timeout got tx_ready %b want 1", tx_ready);
      end
      tick(1);
      tx_valid = 1'b0;
      checks++;
      if (tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_ready got %b want 0", tx_ready);
      end
   endtask

   task automatic xfer(input logic [7:0] mo, input int nbits,
                       output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = mo[i];
         tick(6);
         sclk = 1'b1;
         mi[i] = miso;
         tick(6);
         sclk = 1'b0;
      end
   endtask

   task automatic cs_start();
      cs_n = 1'b0;
      tick(8);
   endtask

   task automatic cs_end();
      tick(4);
      cs_n = 1'b1;
      tick(10);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      checks++;
      if ({miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_err}
          !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs got %b%b %h %b%b%b%b want 01 00 0000",
                  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun,
                  frame_err);
      end
      rst = 1'b0;
      tick(4);
   endtask

   task automatic test_single();
      logic [7:0] mi;
      int r0;
      r0 = rxv_cnt;
      load(8'hA5);
      cs_start();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy got %b want 1", busy);
      end
      exp_rx.push_back(8'h3C);
      xfer(8'h3C, 8, mi);
      checks++;
      if (mi !== 8'hA5) begin
         errors++;
         $display("FAIL single_miso got %h want a5", mi);
      end
      cs_end();
      checks++;
      if (rxv_cnt - r0 !== 1) begin
         errors++;
         $display("FAIL single_rxv got %0d want 1", rxv_cnt - r0);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_end got %b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] m1, m2;
      int r0, u0;
      r0 = rxv_cnt;
      u0 = und_cnt;
      load(8'h81);
      fork
         begin
            cs_start();
            exp_rx.push_back(8'h00);
            xfer(8'h00, 8, m1);
            exp_rx.push_back(8'hFF);
            xfer(8'hFF, 8, m2);
            cs_end();
         end
         begin
            tick(30);
            load(8'h7E);
         end
      join
      checks++;
      if (m1 !== 8'h81 || m2 !== 8'h7E) begin
         errors++;
         $display("FAIL b2b_miso got %h %h want 81 7e", m1, m2);
      end
      checks++;
      if (rxv_cnt - r0 !== 2) begin
         errors++;
         $display("FAIL b2b_rxv got %0d want 2", rxv_cnt - r0);
      end
      checks++;
      if (und_cnt !== u0) begin
         errors++;
         $display("FAIL b2b_underrun got %0d want 0", und_cnt - u0);
      end
   endtask

   task automatic test_underrun();
      logic [7:0] mi;
      int u0;
      u0 = und_cnt;
      cs_start();
      exp_rx.push_back(8'h55);
      xfer(8'h55, 8, mi);
      cs_end();
      checks++;
      if (und_cnt - u0 !== 1) begin
         errors++;
         $display("FAIL underrun_count got %0d want 1", und_cnt - u0);
      end
      checks++;
      if (mi !== 8'h00) begin
         errors++;
         $display("FAIL underrun_miso got %h want 00", mi);
      end
      checks++;
      if (rx_data !== 8'h55) begin
         errors++;
         $display("FAIL underrun_rx got %h want 55", rx_data);
      end
   endtask

   task automatic test_abort();
      logic [7:0] mi;
      int r0, f0;
      r0 = rxv_cnt;
      f0 = fe_cnt;
      cs_start();
      xfer(8'hF0, 5, mi);
      cs_end();
      checks++;
      if (rxv_cnt !== r0 || fe_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL abort_pulses got rxv %0d fe %0d want 0 1",
                  rxv_cnt - r0, fe_cnt - f0);
      end
      checks++;
      if (rx_data !== 8'h55 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_state got %h %b want 55 0", rx_data, busy);
      end
      cs_start();
      exp_rx.push_back(8'hC3);
      xfer(8'hC3, 8, mi);
      cs_end();
      checks++;
      if (rx_data !== 8'hC3) begin
         errors++;
         $display("FAIL abort_next got %h want c3", rx_data);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] mi;
      int r0;
      load(8'h5A);
      cs_start();
      xfer(8'hE0, 3, mi);
      rst = 1'b1;
      tick(1);
      checks++;
      if ({miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_err}
          !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL rstmid_outputs got %b%b %h %b%b%b%b want 01 00 0000",
                  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun,
                  frame_err);
      end
      tick(1);
      rst = 1'b0;
      r0 = rxv_cnt;
      xfer(8'hFF, 8, mi);
      checks++;
      if (rxv_cnt !== r0 || busy !== 1'b0 || mi !== 8'h00 ||
          rx_data !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_idle got rxv %0d busy %b miso %h rx %h want 0 0 00 00",
                  rxv_cnt - r0, busy, mi, rx_data);
      end
      cs_end();
      cs_start();
      exp_rx.push_back(8'h96);
      xfer(8'h96, 8, mi);
      cs_end();
      checks++;
      if (rx_data !== 8'h96) begin
         errors++;
         $display("FAIL rstmid_next got %h want 96", rx_data);
      end
   endtask

   task automatic test_handshake();
      logic [7:0] mi;
      logic bad;
      bad = 1'b0;
      load(8'h11);
      tx_data = 8'h22;
      tx_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (tx_ready !== 1'b0) bad = 1'b1;
      end
      tx_valid = 1'b0;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL hs_ready got 1 want 0");
      end
      cs_start();
      exp_rx.push_back(8'h00);
      xfer(8'h00, 8, mi);
      cs_end();
      checks++;
      if (mi !== 8'h11) begin
         errors++;
         $display("FAIL hs_miso got %h want 11", mi);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_reset_mid();
      test_handshake();
      checks++;
      if (exp_rx.size() != 0) begin
         errors++;
         $display("FAIL rx_missing got %0d left want 0", exp_rx.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule
